// File: rtl/npu_q_pkg.sv
// Shared int8 quantization constants: output range, pipeline depth and
// MLC_SCALE field positions.
package npu_q_pkg;

    localparam int QMIN      = -128;
    localparam int QMAX      = 127;
    localparam int Q_LATENCY = 3;

    localparam int SCALE_M_LSB = 0;
    localparam int SCALE_M_MSB = 15;
    localparam int SCALE_S_LSB = 16;
    localparam int SCALE_S_MSB = 20;
    localparam int SCALE_Z_LSB = 24;
    localparam int SCALE_Z_MSB = 31;

endpackage

// File: rtl/q_round_sat8.sv
// Combinational requantize core: round-half-up arithmetic shift, zero-point
// add and clamp to int8, with a flag raised whenever the clamp engages.
module q_round_sat8
    import npu_q_pkg::*;
(
    input  logic signed [31:0] p,
    input  logic        [4:0]  shift,
    input  logic signed [7:0]  zp,
    output logic        [7:0]  q,
    output logic               sat
);

    localparam logic signed [33:0] VMAX = 34'(QMAX);
    localparam logic signed [33:0] VMIN = 34'(QMIN);

    logic signed [32:0] p_ext;
    logic signed [32:0] bias;
    logic signed [32:0] sum;
    logic signed [32:0] r;
    logic signed [33:0] v;

    // 33 bits hold P plus a bias of at most 2^30 without overflow
    always_comb begin
        p_ext = {p[31], p};
        bias  = '0;
        if (shift != 5'd0)
            bias = 33'sd1 <<< (shift - 5'd1);
        sum = p_ext + bias;
        r   = sum >>> shift;
        v   = {r[32], r} + {{26{zp[7]}}, zp};
        sat = 1'b0;
        q   = v[7:0];
        if (v > VMAX) begin
            q   = 8'(QMAX);
            sat = 1'b1;
        end else if (v < VMIN) begin
            q   = 8'(QMIN);
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/q_requant8.sv
// Three-stage int16 -> int8 requantizer (multiply, round-shift, zero point,
// clamp) with ready/valid backpressure and a saturation event counter.
module q_requant8
    import npu_q_pkg::*;
#(
    parameter int LATENCY = Q_LATENCY
) (
    input  logic        CLK,
    input  logic        RESET_X,
    input  logic        INPUT_EN,
    output logic        INPUT_RDY,
    input  logic [15:0] D_IN,
    input  logic [31:0] MLC_SCALE,
    output logic        OUTPUT_EN,
    input  logic        OUTPUT_RDY,
    output logic [7:0]  Q_OUT,
    input  logic        SAT_CLR,
    output logic [15:0] SAT_CNT
);

    logic               adv;
    logic               accept;
    logic [LATENCY-1:0] vld;

    logic signed [15:0] s1_d;
    logic signed [15:0] s1_m;
    logic        [4:0]  s1_s;
    logic signed [7:0]  s1_z;

    logic signed [31:0] s2_p;
    logic        [4:0]  s2_s;
    logic signed [7:0]  s2_z;

    logic [7:0]  q_nx;
    logic        sat_nx;
    logic [7:0]  q_r;
    logic        sat_r;
    logic [15:0] sat_cnt_r;

    logic unused_scale_bits;
    assign unused_scale_bits = ^MLC_SCALE[SCALE_Z_LSB-1:SCALE_S_MSB+1];

    // whole pipeline moves as one; a stalled output still lets all stages shift
    // the moment it drains
    assign adv       = !vld[LATENCY-1] || OUTPUT_RDY;
    assign accept    = INPUT_EN && adv;
    assign INPUT_RDY = adv;
    assign OUTPUT_EN = vld[LATENCY-1];
    assign Q_OUT     = q_r;
    assign SAT_CNT   = sat_cnt_r;

    q_round_sat8 u_round_sat (
        .p     (s2_p),
        .shift (s2_s),
        .zp    (s2_z),
        .q     (q_nx),
        .sat   (sat_nx)
    );

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X) begin
            vld   <= '0;
            s1_d  <= '0;
            s1_m  <= '0;
            s1_s  <= '0;
            s1_z  <= '0;
            s2_p  <= '0;
            s2_s  <= '0;
            s2_z  <= '0;
            q_r   <= '0;
            sat_r <= 1'b0;
        end else if (adv) begin
            vld   <= {vld[LATENCY-2:0], accept};
            s1_d  <= D_IN;
            s1_m  <= MLC_SCALE[SCALE_M_MSB:SCALE_M_LSB];
            s1_s  <= MLC_SCALE[SCALE_S_MSB:SCALE_S_LSB];
            s1_z  <= MLC_SCALE[SCALE_Z_MSB:SCALE_Z_LSB];
            s2_p  <= 32'(s1_d) * 32'(s1_m);
            s2_s  <= s1_s;
            s2_z  <= s1_z;
            q_r   <= q_nx;
            sat_r <= sat_nx;
        end
    end

    always_ff @(posedge CLK or negedge RESET_X) begin
        if (!RESET_X)
            sat_cnt_r <= '0;
        else if (SAT_CLR)
            sat_cnt_r <= '0;
        else if (OUTPUT_EN && OUTPUT_RDY && sat_r && sat_cnt_r != 16'hFFFF)
            sat_cnt_r <= sat_cnt_r + 16'd1;
    end

endmodule

// File: doc/q_requant8.md
Q_REQUANT8 -- requirements
Module: q_requant8

Interface
REQ-001 SHALL have the following ports.
- CLK  in  1  clock, all state on rising edge.
- RESET_X  in  1  reset, asynchronous, active-low.
- INPUT_EN  in  1  input beat valid.
- INPUT_RDY  out  1  block can accept a beat this cycle.
- D_IN  in  16  signed two's-complement product/accumulator value.
- MLC_SCALE  in  32  config, sampled with each accepted beat:
  - [15:0] signed multiplier M.
  - [20:16] unsigned shift S (0..31).
  - [31:24] signed zero point Z.
- OUTPUT_EN  out  1  output beat valid.
- OUTPUT_RDY  in  1  downstream accepts the beat.
- Q_OUT  out  8  signed int8 quantized result.
- SAT_CLR  in  1  synchronous clear of SAT_CNT.
- SAT_CNT  out  16  count of saturated output beats.
REQ-002 SHALL have parameter LATENCY, default 3, meaning cycles from accepted input to OUTPUT_EN with no stall.

Function
REQ-003 SHALL accept a beat when INPUT_EN=1 and INPUT_RDY=1 in the same cycle.
REQ-004 SHALL run a 3-stage pipeline:
- S1 registers D_IN and MLC_SCALE.
- S2 registers signed 32-bit P = D*M.
- S3 registers Q_OUT, OUTPUT_EN and the saturation flag.
REQ-005 SHALL advance all stages together on adv = (!OUTPUT_EN || OUTPUT_RDY); INPUT_RDY = adv, combinational.
REQ-006 SHALL hold every stage register and its valid bit unchanged when adv=0.
REQ-007 SHALL compute R = P when S=0, else R = (P + 2^(S-1)) >>> S, in 33-bit signed arithmetic with no intermediate overflow.
REQ-008 SHALL round half toward +infinity, e.g. 3/2 -> 2 and -3/2 -> -1.
REQ-009 SHALL compute V = R + Z, sign-extended to 34 bits.
REQ-010 SHALL set Q_OUT = 127 if V>127, -128 if V<-128, else V[7:0]; the saturation flag is set when clamping occurs.
REQ-011 SHALL hold Q_OUT stable while OUTPUT_EN=1 and OUTPUT_RDY=0.
REQ-012 SHALL sustain one beat per cycle with OUTPUT_RDY held at 1.
REQ-013 SHALL emit beats in acceptance order and never drop or duplicate a beat.
REQ-014 SHALL increment SAT_CNT once per output beat transferred (OUTPUT_EN and OUTPUT_RDY both 1) whose saturation flag is set.
- SAT_CNT saturates at 0xFFFF.
REQ-015 SHALL give SAT_CLR priority over a simultaneous increment; SAT_CNT=0 next cycle.
REQ-016 SHALL let bubbles (INPUT_EN=0) propagate as invalid stages, and SHALL let a stalled output stage be refilled in the same cycle it drains.

Reset
REQ-017 SHALL, while RESET_X=0, force all stage valid bits to 0, OUTPUT_EN=0, Q_OUT=0x00 and SAT_CNT=0x0000.
REQ-018 SHALL drive INPUT_RDY=1 during and immediately after reset, since the pipeline is empty.
REQ-019 SHALL discard all in-flight beats on reset asserted mid-stream; no OUTPUT_EN pulse follows release until new input is accepted.

Structure
REQ-020 SHALL take the following constants from shared package npu_q_pkg:
- QMIN=-128 and QMAX=127.
- Q_LATENCY=3.
- MLC_SCALE field bit positions.
REQ-021 SHALL instantiate one combinational sub-module q_round_sat8, which performs the round-shift, zero-point add and clamp and also outputs the saturation flag.

Verification
REQ-022 Bench SHALL cover these scenarios:
- D=100, M=16384, S=15, Z=0, OUTPUT_RDY=1 -> Q_OUT=50 (0x32) exactly 3 cycles after acceptance, SAT_CNT unchanged.
- Rounding: D=3, M=1, S=1 -> Q_OUT=2. D=-3, M=1, S=1 -> Q_OUT=-1 (0xFF).
- Saturation: D=1000, M=1, S=0 -> 127 (0x7F). D=-1000, M=1, S=0 -> -128 (0x80). SAT_CNT=2. Then SAT_CLR pulse -> SAT_CNT=0.
- Zero point: D=0, M=1, S=0, Z=-5 -> Q_OUT=0xFB. D=124, Z=+5 -> 127, saturation flag set.
- Backpressure: 10 back-to-back beats D=1..10 (M=1, S=0), OUTPUT_RDY low for cycles 4-8 -> INPUT_RDY low while stalled, outputs exactly 1..10 in order, Q_OUT held during stall.
- Reset mid-stream: assert RESET_X low with 3 beats in flight -> OUTPUT_EN=0, SAT_CNT=0, no stale beat after release.
